// File: rtl/pwr_domain_ctrl_if.sv
// Power-domain sequencer bus: PMU level requests, power-switch handshake
// and the control/status lines driven into the execution-unit domain.
interface pwr_domain_ctrl_if;
    logic pwr_down;
    logic iso_enable;
    logic sw_ack;
    logic sw_en;
    logic iso_out;
    logic save_out;
    logic restore_out;
    logic dom_rst;
    logic dom_on;
    logic err;

    // PMU / switch-chain side driving the sequencer
    modport master (
        output pwr_down,
        output iso_enable,
        output sw_ack,
        input  sw_en,
        input  iso_out,
        input  save_out,
        input  restore_out,
        input  dom_rst,
        input  dom_on,
        input  err
    );

    // Sequencer side
    modport slave (
        input  pwr_down,
        input  iso_enable,
        input  sw_ack,
        output sw_en,
        output iso_out,
        output save_out,
        output restore_out,
        output dom_rst,
        output dom_on,
        output err
    );
endinterface

// File: rtl/pwr_domain_ctrl.sv
// Power-domain sequencer for the execution-unit domain.
// Turns PMU pwr_down/iso_enable levels into ordered isolate/save/switch-off
// and switch-on/settle/reset/restore/de-isolate sequences, handshaking with
// the power-switch chain acknowledge.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ON         | domain powered, released, de-isolated
// ISO        | clamps applied, waiting for pwr_down or release of request
// SAVE       | one-cycle retention save pulse
// SW_OFF     | switch disabled, waiting for sw_ack=0 (timeout -> err)
// OFF        | domain off, isolated, held in reset
// SW_ON      | switch enabled; phase 1 waits for sw_ack, phase 2 settles
// RESET      | domain reset held after settle
// RESTORE    | one-cycle retention restore pulse (only if a save happened)
// DEISO      | powered and released, still isolated until iso_enable drops
//
// All outputs are decoded from registered state only.
module pwr_domain_ctrl #(
    parameter int RAMP_CYCLES = 8,
    parameter int RST_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input logic              clk,
    input logic              rst,
    pwr_domain_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        ST_ON      = 4'd0,
        ST_ISO     = 4'd1,
        ST_SAVE    = 4'd2,
        ST_SW_OFF  = 4'd3,
        ST_OFF     = 4'd4,
        ST_SW_ON   = 4'd5,
        ST_RESET   = 4'd6,
        ST_RESTORE = 4'd7,
        ST_DEISO   = 4'd8
    } state_t;

    // Settle exits when cnt reaches RAMP_CYCLES: the cycle in which sw_ack
    // was first sampled counts as its own cycle ahead of the ramp window.
    localparam logic [7:0] RAMP_LAST = 8'(RAMP_CYCLES);
    localparam logic [7:0] RST_LAST  = 8'(RST_CYCLES - 1);
    localparam logic [7:0] ACK_LAST  = 8'(ACK_TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       ack_phase;      // SW_ON only: 0 = waiting for sw_ack, 1 = settling
    logic       ack_phase_nxt;
    logic [7:0] cnt;
    logic       err_q;
    logic       saved_q;
    logic       err_set;

    // State register, shared cycle counter and sticky err/saved flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_OFF;
            ack_phase <= 1'b0;
            cnt       <= 8'd0;
            err_q     <= 1'b0;
            saved_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ack_phase <= ack_phase_nxt;
            if ((state_nxt != state) || (ack_phase_nxt != ack_phase)) begin
                cnt <= 8'd0;
            end else if (cnt != 8'hFF) begin
                cnt <= cnt + 8'd1;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (state == ST_SAVE) begin
                saved_q <= 1'b1;
            end
        end
    end

    // Next-state decode; started sequences always run to OFF or DEISO
    always_comb begin
        state_nxt     = state;
        ack_phase_nxt = 1'b0;
        err_set       = 1'b0;
        case (state)
            ST_ON: begin
                if (bus.iso_enable || bus.pwr_down) begin
                    state_nxt = ST_ISO;
                end
            end
            ST_ISO: begin
                if (bus.pwr_down) begin
                    state_nxt = ST_SAVE;
                end else if (!bus.iso_enable) begin
                    state_nxt = ST_ON;
                end
            end
            ST_SAVE: begin
                state_nxt = ST_SW_OFF;
            end
            ST_SW_OFF: begin
                if (!bus.sw_ack) begin
                    state_nxt = ST_OFF;
                end else if (cnt == ACK_LAST) begin
                    err_set   = 1'b1;
                    state_nxt = ST_OFF;
                end
            end
            ST_OFF: begin
                if (!bus.pwr_down) begin
                    state_nxt = ST_SW_ON;
                end
            end
            ST_SW_ON: begin
                if (!ack_phase) begin
                    if (bus.sw_ack) begin
                        ack_phase_nxt = 1'b1;
                    end else if (cnt == ACK_LAST) begin
                        err_set   = 1'b1;
                        state_nxt = ST_OFF;
                    end
                end else begin
                    if (!bus.sw_ack) begin
                        ack_phase_nxt = 1'b0;
                    end else if (cnt == RAMP_LAST) begin
                        state_nxt = ST_RESET;
                    end else begin
                        ack_phase_nxt = 1'b1;
                    end
                end
            end
            ST_RESET: begin
                if (cnt == RST_LAST) begin
                    state_nxt = ST_RESTORE;
                end
            end
            ST_RESTORE: begin
                state_nxt = ST_DEISO;
            end
            ST_DEISO: begin
                if (bus.pwr_down) begin
                    state_nxt = ST_SAVE;
                end else if (!bus.iso_enable) begin
                    state_nxt = ST_ON;
                end
            end
            default: begin
                state_nxt = ST_OFF;
            end
        endcase
    end

    // Moore output decode; defaults are the safe powered-off values
    always_comb begin
        bus.sw_en       = 1'b0;
        bus.iso_out     = 1'b1;
        bus.save_out    = 1'b0;
        bus.restore_out = 1'b0;
        bus.dom_rst     = 1'b1;
        bus.dom_on      = 1'b0;
        case (state)
            ST_ON: begin
                bus.sw_en   = 1'b1;
                bus.iso_out = 1'b0;
                bus.dom_rst = 1'b0;
                bus.dom_on  = 1'b1;
            end
            ST_ISO: begin
                bus.sw_en   = 1'b1;
                bus.dom_rst = 1'b0;
            end
            ST_SAVE: begin
                bus.sw_en    = 1'b1;
                bus.dom_rst  = 1'b0;
                bus.save_out = 1'b1;
            end
            ST_SW_OFF: begin
                bus.dom_rst = 1'b0;
            end
            ST_OFF: begin
                bus.dom_rst = 1'b1;
            end
            ST_SW_ON: begin
                bus.sw_en = 1'b1;
            end
            ST_RESET: begin
                bus.sw_en = 1'b1;
            end
            ST_RESTORE: begin
                bus.sw_en       = 1'b1;
                bus.dom_rst     = 1'b0;
                bus.restore_out = saved_q;
            end
            ST_DEISO: begin
                bus.sw_en   = 1'b1;
                bus.dom_rst = 1'b0;
            end
            default: begin
                bus.sw_en = 1'b0;
            end
        endcase
    end

    assign bus.err = err_q;

endmodule

// File: tb/tb_pwr_domain_ctrl.sv
// Directed bench for pwr_domain_ctrl with default parameters.
// Power-switch chain model: sw_ack follows sw_en with a 2-cycle lag unless forced.
module tb_pwr_domain_ctrl;

    logic clk = 1'b0;
    logic rst;

    pwr_domain_ctrl_if bus();

    pwr_domain_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic ack_d1    = 1'b0;
    logic ack_d2    = 1'b0;
    logic ack_force = 1'b0;
    logic ack_val   = 1'b0;

    always @(posedge clk) begin
        ack_d1 <= bus.sw_en;
        ack_d2 <= ack_d1;
    end

    assign bus.sw_ack = ack_force ? ack_val : ack_d2;

    // {sw_en, iso_out, save_out, restore_out, dom_rst, dom_on, err}
    logic [6:0] outs;
    assign outs = {bus.sw_en, bus.iso_out, bus.save_out, bus.restore_out,
                   bus.dom_rst, bus.dom_on, bus.err};

    localparam logic [6:0] O_OFF     = 7'b0100100;
    localparam logic [6:0] O_SWON    = 7'b1100100;
    localparam logic [6:0] O_ON      = 7'b1000010;
    localparam logic [6:0] O_ISO     = 7'b1100000;
    localparam logic [6:0] O_SAVE    = 7'b1110000;
    localparam logic [6:0] O_SWOFF   = 7'b0100000;
    localparam logic [6:0] O_RESTORE = 7'b1101000;
    localparam logic [6:0] O_ERR     = 7'b0000001;

    typedef struct {
        logic       pd;
        logic       iso;
        logic [6:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[64];
    int   nvec   = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic add_vec(input logic pd, input logic iso, input logic [6:0] exp, input string name);
        vecs[nvec] = '{pd, iso, exp, name};
        nvec++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [6:0] exp);
        checks++;
        if (outs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (sw_en iso save restore dom_rst dom_on err)",
                     name, outs, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Called in OFF with pwr_down=0, iso_enable=0; next edge enters SW_ON (cycle 0)
    task automatic power_up(input string name, input int exp_lat, input int exp_restores);
        int lat   = -1;
        int nrest = 0;
        int nerr  = 0;
        step();
        chk({name, "_swon"}, O_SWON);
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            step();
            if (outs[3]) nrest++;
            if (outs[0]) nerr++;
            if (outs[1]) lat = c;
        end
        chk_int({name, "_latency"}, lat, exp_lat);
        chk_int({name, "_restores"}, nrest, exp_restores);
        chk_int({name, "_err_cycles"}, nerr, 0);
    endtask

    initial begin
        int on_seen;
        int err_low;

        rst            = 1'b1;
        bus.pwr_down   = 1'b0;
        bus.iso_enable = 1'b0;
        repeat (3) step();
        chk("reset_state", O_OFF);
        rst = 1'b0;

        // Cold power-up: no restore, dom_on 18 cycles after first SW_ON cycle
        power_up("cold", 18, 0);

        // Isolate, power down, then power back up with isolation still requested
        add_vec(1'b0, 1'b1, O_ISO,   "iso_first");
        add_vec(1'b1, 1'b1, O_SAVE,  "save_pulse");
        add_vec(1'b1, 1'b1, O_SWOFF, "sw_off");
        add_vec(1'b1, 1'b1, O_SWOFF, "sw_off_wait1");
        add_vec(1'b1, 1'b1, O_SWOFF, "sw_off_wait2");
        add_vec(1'b1, 1'b1, O_OFF,   "off_after_ack");
        add_vec(1'b1, 1'b1, O_OFF,   "off_hold");
        add_vec(1'b0, 1'b1, O_SWON,  "up_swon");
        for (int i = 1; i <= 11; i++) add_vec(1'b0, 1'b1, O_SWON, "up_settle");
        for (int i = 0; i < 4; i++)   add_vec(1'b0, 1'b1, O_SWON, "up_dom_reset");
        add_vec(1'b0, 1'b1, O_RESTORE, "up_restore");
        add_vec(1'b0, 1'b1, O_ISO,     "up_deiso_hold1");
        add_vec(1'b0, 1'b1, O_ISO,     "up_deiso_hold2");
        add_vec(1'b0, 1'b0, O_ON,      "up_on");

        for (int i = 0; i < nvec; i++) begin
            bus.pwr_down   = vecs[i].pd;
            bus.iso_enable = vecs[i].iso;
            step();
            chk(vecs[i].name, vecs[i].exp);
        end

        // Switch-off timeout with sw_ack stuck high
        ack_force    = 1'b1;
        ack_val      = 1'b1;
        bus.pwr_down = 1'b1;
        step();
        chk("to_iso", O_ISO);
        step();
        chk("to_save", O_SAVE);
        step();
        chk("to_swoff", O_SWOFF);
        repeat (63) step();
        chk("swoff_before_timeout", O_SWOFF);
        step();
        chk("swoff_timeout", O_OFF | O_ERR);

        // Switch-on timeouts with sw_ack stuck low
        ack_val      = 1'b0;
        bus.pwr_down = 1'b0;
        step();
        chk("swon_enter", O_SWON | O_ERR);
        repeat (63) step();
        chk("swon_before_timeout", O_SWON | O_ERR);
        step();
        chk("swon_timeout", O_OFF | O_ERR);
        step();
        chk("swon_retry", O_SWON | O_ERR);
        on_seen = 0;
        err_low = 0;
        for (int c = 0; c < 150; c++) begin
            step();
            if (outs[1])  on_seen++;
            if (!outs[0]) err_low++;
        end
        chk_int("stuck_dom_on_cycles", on_seen, 0);
        chk_int("stuck_err_low_cycles", err_low, 0);

        // Reset clears err; warm power-up without a save
        ack_force = 1'b0;
        rst       = 1'b1;
        repeat (3) step();
        chk("reset_clears_err", O_OFF);
        rst = 1'b0;
        power_up("warm", 18, 0);

        // pwr_down dropped during SW_OFF still reaches OFF before power-up
        bus.pwr_down = 1'b1;
        step();
        chk("mid_iso", O_ISO);
        step();
        chk("mid_save", O_SAVE);
        step();
        chk("mid_swoff", O_SWOFF);
        bus.pwr_down = 1'b0;
        step();
        chk("mid_swoff_hold1", O_SWOFF);
        step();
        chk("mid_swoff_hold2", O_SWOFF);
        step();
        chk("mid_off_reached", O_OFF);
        step();
        chk("mid_swon", O_SWON);

        // pwr_down reasserted in RESET: RESTORE, DEISO, then SAVE again
        repeat (12) step();
        chk("mid_in_reset", O_SWON);
        bus.pwr_down = 1'b1;
        repeat (4) step();
        chk("mid_restore", O_RESTORE);
        step();
        chk("mid_deiso", O_ISO);
        step();
        chk("mid_resave", O_SAVE);
        step();
        chk("mid_reswoff", O_SWOFF);

        // rst during RESET: reset values, then saved is gone (no restore)
        bus.pwr_down = 1'b0;
        repeat (4) step();
        chk("rr_swon", O_SWON);
        repeat (12) step();
        chk("rr_in_reset", O_SWON);
        rst = 1'b1;
        step();
        chk("rst_in_reset", O_OFF);
        repeat (2) step();
        rst = 1'b0;
        power_up("after_rst_reset", 18, 0);

        // rst during SAVE: no save pulse follows, reset values next cycle
        bus.pwr_down = 1'b1;
        step();
        chk("rs_iso", O_ISO);
        step();
        chk("rs_save", O_SAVE);
        rst          = 1'b1;
        bus.pwr_down = 1'b0;
        step();
        chk("rst_in_save", O_OFF);
        repeat (2) step();
        rst = 1'b0;
        power_up("after_rst_save", 18, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
